// File: rtl/dec_bpv_seq.sv
// BPV parse sequencer: reads one fixed-length BPV per consume from the substream window and fills the BP partition slots.
// Optional bit counter output bits_used is enabled by defining DEC_BPV_SEQ_BITCNT_EN.
module dec_bpv_seq #(
   parameter int SSM_IDX  = 0,
   parameter int NUM_PART = 4,
   parameter int BPV_BITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    mode_bp,
   input  logic [NUM_PART-1:0]     use2x2_map,
   input  logic                    win_valid,
   input  logic [15:0]             win_data,
   output logic                    win_consume,
   output logic [3:0]              win_nbits,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_PART*12-1:0]  bpv_out
`ifdef DEC_BPV_SEQ_BITCNT_EN
   ,
   output logic [7:0]              bits_used
`endif
);

   localparam int PW = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;

   if (BPV_BITS < 1 || BPV_BITS > 7 || NUM_PART < 1 || SSM_IDX < 0) begin : g_param_check
      $error("dec_bpv_seq: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

   state_e                 state_q;
   logic                   busy_q;
   logic                   done_q;
   logic [NUM_PART-1:0]    map_q;
   logic [PW-1:0]          part_q;
   logic                   half_q;
   logic [NUM_PART*12-1:0] bpv_q;

   logic [7:0] code_ext_d;
   logic [5:0] val_d;
   logic       is2x2_d;
   logic       part_done_d;
   logic       last_part_d;

   // Low window bits below the BPV field are intentionally ignored.
   logic unused_win;
   assign unused_win = ^win_data[15-BPV_BITS:0];

   assign win_consume = (state_q == READ) & win_valid;
   assign win_nbits   = win_consume ? 4'(BPV_BITS) : 4'd0;
   assign busy        = busy_q;
   assign done        = done_q;
   assign bpv_out     = bpv_q;

   // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      code_ext_d  = 8'(win_data[15 -: BPV_BITS]);
      val_d       = 6'(code_ext_d + 8'd32);
      is2x2_d     = map_q[part_q];
      part_done_d = is2x2_d | half_q;
      last_part_d = (part_q == PW'(NUM_PART - 1));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         map_q   <= '0;
         part_q  <= '0;
         half_q  <= 1'b0;
         bpv_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  map_q  <= use2x2_map;
                  bpv_q  <= '0;
                  part_q <= '0;
                  half_q <= 1'b0;
                  busy_q <= 1'b1;
                  if (mode_bp) begin
                     state_q <= READ;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (win_valid) begin
                  // A 2x2 partition fills both halves from a single BPV.
                  if (is2x2_d || !half_q) bpv_q[12*int'(part_q) +: 6]     <= val_d;
                  if (is2x2_d ||  half_q) bpv_q[12*int'(part_q) + 6 +: 6] <= val_d;
                  if (part_done_d) begin
                     half_q <= 1'b0;
                     if (last_part_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        part_q <= part_q + 1'b1;
                     end
                  end else begin
                     half_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEC_BPV_SEQ_BITCNT_EN
   logic [7:0] bits_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q <= '0;
      end else if (state_q == IDLE && start) begin
         bits_q <= '0;
      end else if (win_consume) begin
         bits_q <= bits_q + 8'(BPV_BITS);
      end
   end

   assign bits_used = bits_q;
`endif

endmodule
